// File: rtl/ahb_lite_mem_slave_param.sv
// AHB-Lite on-chip RAM target: configurable depth and wait states, HSIZE byte strobes,
// two-cycle ERROR response for illegal accesses and write-to-read forwarding.
module ahb_lite_mem_slave_param #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic              i_hclk,
  input  logic              i_hreset,
  input  logic              i_hsel,
  input  logic [ADDR_W-1:0] i_haddr,
  input  logic              i_hwrite,
  input  logic [2:0]        i_hsize,
  input  logic [1:0]        i_htrans,
  input  logic [31:0]       i_hwdata,
  input  logic              i_hready,
  input  logic              i_work,
  output logic [31:0]       o_hrdata,
  output logic              o_hreadyout,
  output logic              o_hresp
);

  localparam int              IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT    = (ADDR_W + 1)'(DEPTH * 4);
  localparam logic [2:0]      CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic             r_pend;
  logic [IDX_W-1:0] r_idx;
  logic             r_write;
  logic [3:0]       r_strb;
  logic [31:0]      r_hrdata;
  logic             r_hreadyout;
  logic             r_hresp;
  logic [31:0]      r_mem [DEPTH];

  logic             w_accept;
  logic             w_size_ok;
  logic             w_align_ok;
  logic             w_range_ok;
  logic             w_legal;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_strb;
  logic             w_commit;
  logic             w_rd_load;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_fwd_hit;
  logic [31:0]      w_mem_word;
  logic [31:0]      w_rd_word;
  logic             w_unused;

  assign w_unused = i_htrans[0];

  // A new address phase is only taken while no data phase is stalling the bus.
  assign w_accept = i_hsel & i_hready & i_htrans[1] &
                    ((r_state == ST_IDLE) | (r_state == ST_ERR2));

  assign w_size_ok  = (i_hsize <= 3'd2);
  assign w_align_ok = !(((i_hsize == 3'd1) && i_haddr[0]) ||
                        ((i_hsize == 3'd2) && (i_haddr[1:0] != 2'b00)));
  assign w_range_ok = ({1'b0, i_haddr} < LIMIT);
  assign w_legal    = w_size_ok & w_align_ok & w_range_ok & i_work;
  assign w_idx      = i_haddr[IDX_W+1:2];

  always_comb begin
    w_strb = 4'b0000;
    case (i_hsize)
      3'd0:    w_strb = 4'b0001 << i_haddr[1:0];
      3'd1:    w_strb = i_haddr[1] ? 4'b1100 : 4'b0011;
      3'd2:    w_strb = 4'b1111;
      default: w_strb = 4'b0000;
    endcase
  end

  // The completing cycle of a legal transfer is the IDLE state with r_pend set.
  assign w_commit = (r_state == ST_IDLE) & r_pend & r_write;

  generate
    if (WAIT_STATES == 0) begin : g_ws0
      assign w_rd_load = w_accept & w_legal & ~i_hwrite;
      assign w_rd_idx  = w_idx;
    end else begin : g_wsn
      assign w_rd_load = (r_state == ST_WAIT) & (r_cnt == 3'd0) & ~r_write;
      assign w_rd_idx  = r_idx;
    end
  endgenerate

  assign w_fwd_hit  = w_commit & (w_rd_idx == r_idx);
  assign w_mem_word = r_mem[w_rd_idx];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_rd_word[8*gi +: 8] = (w_fwd_hit & r_strb[gi]) ? i_hwdata[8*gi +: 8]
                                                            : w_mem_word[8*gi +: 8];
  end

  always_ff @(posedge i_hclk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_strb[b]) begin
          r_mem[r_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_hrdata <= 32'd0;
    end else if (w_rd_load) begin
      r_hrdata <= w_rd_word;
    end
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_pend      <= 1'b0;
      r_idx       <= '0;
      r_write     <= 1'b0;
      r_strb      <= 4'b0000;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERR2: begin
          if (w_accept) begin
            r_idx   <= w_idx;
            r_write <= i_hwrite;
            r_strb  <= w_strb;
            if (!w_legal) begin
              r_state     <= ST_ERR1;
              r_pend      <= 1'b0;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              r_state     <= ST_IDLE;
              r_pend      <= 1'b1;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
            end else begin
              r_state     <= ST_WAIT;
              r_cnt       <= CNT_INIT;
              r_pend      <= 1'b0;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
            end
          end else begin
            r_state     <= ST_IDLE;
            r_pend      <= 1'b0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state     <= ST_IDLE;
            r_pend      <= 1'b1;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_pend      <= 1'b0;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
        end
      endcase
    end
  end

  assign o_hrdata    = r_hrdata;
  assign o_hreadyout = r_hreadyout;
  assign o_hresp     = r_hresp;

endmodule

// File: tb/tb_ahb_lite_mem_slave_param.sv
// Bench for ahb_lite_mem_slave_param: two instances (0 and 3 wait states) driven by a
// pipelined master, checked by a monitor against a byte-level sequential memory model.
`timescale 1ns/1ps
module tb_ahb_lite_mem_slave_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;

  typedef struct {
    bit          wr;
    bit          sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          work;
  } cmd_t;

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
  } exp_t;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic cmd_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wdata, input bit work);
    cmd_t c;
    c.wr = wr; c.sel = 1'b1; c.trans = 2'b10; c.addr = addr;
    c.size = size; c.wdata = wdata; c.work = work;
    return c;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int WS    = (gi == 0) ? 0 : 3;
    localparam int DEPTH = (gi == 0) ? 1024 : 256;
    localparam int AW    = (gi == 0) ? 13 : 12;
    localparam int LIMIT = DEPTH * 4;

    logic          rst    = 1'b1;
    logic          hsel   = 1'b0;
    logic [AW-1:0] haddr  = '0;
    logic          hwrite = 1'b0;
    logic [2:0]    hsize  = 3'd0;
    logic [1:0]    htrans = 2'b00;
    logic [31:0]   hwdata = 32'd0;
    logic          work   = 1'b1;
    logic          hold   = 1'b0;
    logic          hready;
    logic [31:0]   hrdata;
    logic          hreadyout;
    logic          hresp;

    assign hready = hreadyout & ~hold;

    ahb_lite_mem_slave_param #(
      .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_STATES(WS)
    ) u_dut (
      .i_hclk(clk), .i_hreset(rst), .i_hsel(hsel), .i_haddr(haddr),
      .i_hwrite(hwrite), .i_hsize(hsize), .i_htrans(htrans), .i_hwdata(hwdata),
      .i_hready(hready), .i_work(work), .o_hrdata(hrdata),
      .o_hreadyout(hreadyout), .o_hresp(hresp)
    );

    logic [7:0]  mdl [int];
    logic [31:0] last_rd = 32'd0;
    exp_t        q[$];
    bit          has_dp = 1'b0;

    // Sequential memory semantics: transfers complete in issue order, so applying each
    // one to the byte model at issue time gives the value every later read must see.
    function automatic exp_t model(input cmd_t c);
      exp_t e;
      int   nb;
      bit   legal;
      nb    = 1 << c.size;
      legal = (c.size <= 3'd2) && ((int'(c.addr) % nb) == 0) && (int'(c.addr) < LIMIT) && c.work;
      e.wr    = c.wr;
      e.err   = !legal;
      e.addr  = c.addr;
      e.waits = legal ? WS : 1;
      if (legal) begin
        if (c.wr) begin
          for (int k = 0; k < nb; k++) begin
            int a;
            a = int'(c.addr) + k;
            mdl[a] = c.wdata[8*(a % 4) +: 8];
          end
        end else begin
          int base;
          base = int'(c.addr) & ~3;
          last_rd = {mdl[base+3], mdl[base+2], mdl[base+1], mdl[base]};
        end
      end
      e.data = last_rd;
      return e;
    endfunction

    function automatic cmd_t rnd_cmd();
      cmd_t c;
      int   r;
      r       = $urandom_range(0, 99);
      c.sel   = 1'b1;
      c.trans = 2'b10;
      c.work  = ($urandom_range(0, 15) != 0);
      c.wr    = 1'($urandom_range(0, 1));
      c.size  = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      c.addr  = $urandom_range(0, 79);
      if ($urandom_range(0, 9) != 0) c.addr = c.addr & ~((32'd1 << c.size) - 32'd1);
      if ($urandom_range(0, 19) == 0) c.addr = LIMIT + $urandom_range(0, 60);
      c.wdata = $urandom();
      if (r < 8)       c.trans = 2'b00;
      else if (r < 12) c.trans = 2'b01;
      else if (r < 16) c.sel   = 1'b0;
      else if (r < 40) c.trans = 2'b11;
      return c;
    endfunction

    // Called just after a rising edge; holds the address phase until it is accepted.
    task automatic present(input cmd_t c, input bit abort);
      bit acc;
      int guard;
      guard  = 0;
      hsel   = c.sel;
      htrans = c.trans;
      haddr  = c.addr[AW-1:0];
      hwrite = c.wr;
      hsize  = c.size;
      work   = c.work;
      forever begin
        hold = !has_dp && ($urandom_range(0, 7) == 0);
        @(negedge clk);
        acc = hready;
        @(posedge clk);
        #1;
        if (acc) break;
        guard++;
        if (guard > 40) begin
          n_cmp++;
          n_err++;
          $display("FAIL ws%0d_accept_timeout actual=stalled required=accepted at %0t", WS, $time);
          break;
        end
      end
      hold   = 1'b0;
      has_dp = c.sel && c.trans[1];
      hwdata = (has_dp && c.wr) ? c.wdata : $urandom();
      if (has_dp) begin
        if (abort) q.push_back('{wr: 1'b1, err: 1'b0, addr: c.addr, data: last_rd, waits: WS});
        else       q.push_back(model(c));
      end
    endtask

    initial begin : mon
      bit   in_dp;
      int   low;
      exp_t e;
      in_dp = 1'b0;
      low   = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          in_dp = 1'b0;
          low   = 0;
          q.delete();
          continue;
        end
        if (in_dp) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL ws%0d_queue actual=empty required=entry at %0t", WS, $time);
            in_dp = 1'b0;
          end else if (!hreadyout) begin
            low++;
            check($sformatf("ws%0d_resp_stall", WS), hresp, q[0].err);
          end else begin
            e = q.pop_front();
            check($sformatf("ws%0d_resp", WS), hresp, e.err);
            check($sformatf("ws%0d_wait_cycles", WS), low, e.waits);
            check($sformatf("ws%0d_hrdata", WS), hrdata, e.data);
            $display("ws%0d %s addr=0x%05h resp=%0d hrdata=0x%08h stall=%0d", WS,
                     e.wr ? "WR" : "RD", e.addr, hresp, hrdata, low);
            in_dp = 1'b0;
          end
        end else begin
          check($sformatf("ws%0d_idle_ready", WS), hreadyout, 1);
          check($sformatf("ws%0d_idle_resp", WS), hresp, 0);
        end
        if (hready && hsel && htrans[1]) begin
          in_dp = 1'b1;
          low   = 0;
        end
      end
    end

    initial begin : drv
      cmd_t idle_c;
      idle_c = mk(1'b0, 32'd0, 3'd0, 32'd0, 1'b1);
      idle_c.sel   = 1'b0;
      idle_c.trans = 2'b00;

      repeat (3) @(negedge clk);
      check($sformatf("ws%0d_rst_ready", WS), hreadyout, 1);
      check($sformatf("ws%0d_rst_resp", WS), hresp, 0);
      check($sformatf("ws%0d_rst_hrdata", WS), hrdata, 0);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      for (int w = 0; w < 20; w++) present(mk(1'b1, 32'(4 * w), 3'd2, $urandom() | 32'd1, 1'b1), 1'b0);

      present(mk(1'b1, 32'h010, 3'd2, 32'hDEADBEEF, 1'b1), 1'b0);
      present(mk(1'b0, 32'h010, 3'd2, 32'h0, 1'b1), 1'b0);
      present(mk(1'b1, 32'h010, 3'd2, 32'h11223344, 1'b1), 1'b0);
      present(mk(1'b1, 32'h013, 3'd0, 32'hAA000000, 1'b1), 1'b0);
      present(mk(1'b0, 32'h010, 3'd2, 32'h0, 1'b1), 1'b0);
      present(mk(1'b1, 32'h012, 3'd1, 32'h55660000, 1'b1), 1'b0);
      present(mk(1'b0, 32'h010, 3'd2, 32'h0, 1'b1), 1'b0);
      present(mk(1'b1, 32'h020, 3'd2, 32'h12345678, 1'b1), 1'b0);
      present(mk(1'b0, 32'h020, 3'd2, 32'h0, 1'b1), 1'b0);

      present(mk(1'b0, 32'h002, 3'd2, 32'h0, 1'b1), 1'b0);
      present(mk(1'b1, 32'h010, 3'd3, 32'hFFFFFFFF, 1'b1), 1'b0);
      present(mk(1'b0, 32'(LIMIT), 3'd2, 32'h0, 1'b1), 1'b0);
      present(mk(1'b1, 32'h010, 3'd2, 32'h0BADF00D, 1'b0), 1'b0);
      present(mk(1'b0, 32'h010, 3'd2, 32'h0, 1'b1), 1'b0);
      present(idle_c, 1'b0);

      // Reset lands inside the data phase of a write, which must then never commit.
      present(mk(1'b0, 32'h010, 3'd2, 32'h0, 1'b1), 1'b0);
      present(mk(1'b1, 32'h040, 3'd2, 32'hCAFEF00D, 1'b1), 1'b1);
      hsel   = 1'b0;
      htrans = 2'b00;
      repeat ((WS > 0) ? 1 : 0) begin
        @(posedge clk);
        #1;
      end
      #2 rst = 1'b1;
      #1;
      check($sformatf("ws%0d_async_rst_ready", WS), hreadyout, 1);
      check($sformatf("ws%0d_async_rst_resp", WS), hresp, 0);
      check($sformatf("ws%0d_async_rst_hrdata", WS), hrdata, 0);
      last_rd = 32'd0;
      has_dp  = 1'b0;
      @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      present(mk(1'b0, 32'h040, 3'd2, 32'h0, 1'b1), 1'b0);

      for (int t = 0; t < 250; t++) present(rnd_cmd(), 1'b0);

      present(idle_c, 1'b0);
      present(idle_c, 1'b0);
      repeat (3) @(negedge clk);
      check($sformatf("ws%0d_drain", WS), q.size(), 0);
      n_done++;
    end
  end

  initial begin
    wait (n_done == 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished at %0t", $time);
    $fatal(1, "bench did not finish in time");
  end

endmodule
